// File: rtl/rc_arming_failsafe.sv
// rc_arming_failsafe
// Watches the four raw RC PWM lines for signal loss and runs the arm/disarm
// state machine. Decoded stick values reach the mixer only while armed (or
// while a disarm gesture is being held). Otherwise throttle is forced to zero
// and the other axes are centred.
//
// Ports
//   us_clk                      1 MHz clock, one tick per microsecond
//   resetn                      asynchronous active-low reset
//   *_pwm                       raw receiver lines, asynchronous to us_clk
//   *_val   [VAL_WIDTH-1:0]     decoded stick values from the receiver
//   *_out   [VAL_WIDTH-1:0]     gated stick values to the motor mixer
//   armed                       high only in ARMED
//   failsafe                    high only in FAILSAFE
//   state_out [2:0]             encoded state for the LEDs
//
// state      | meaning
// -----------+-----------------------------------------------------------
// DISARMED   | idle, safe outputs, waiting for the arm gesture
// ARMING     | arm gesture being held, safe outputs
// ARMED      | sticks passed through to the mixer
// DISARMING  | disarm gesture being held, sticks still passed through
// FAILSAFE   | a channel lost its PWM; left only with signal back + low throttle
module rc_arming_failsafe #(
  parameter int VAL_WIDTH        = 8,
  parameter int CENTER_VAL       = 125,
  parameter int ARM_THROTTLE_MAX = 10,
  parameter int ARM_YAW_MIN      = 240,
  parameter int DISARM_YAW_MAX   = 10,
  parameter int HOLD_US          = 1000000,
  parameter int LOSS_TIMEOUT_US  = 50000
) (
  input  logic                 us_clk,
  input  logic                 resetn,
  input  logic                 throttle_pwm,
  input  logic                 yaw_pwm,
  input  logic                 roll_pwm,
  input  logic                 pitch_pwm,
  input  logic [VAL_WIDTH-1:0] throttle_val,
  input  logic [VAL_WIDTH-1:0] yaw_val,
  input  logic [VAL_WIDTH-1:0] roll_val,
  input  logic [VAL_WIDTH-1:0] pitch_val,
  output logic [VAL_WIDTH-1:0] throttle_out,
  output logic [VAL_WIDTH-1:0] yaw_out,
  output logic [VAL_WIDTH-1:0] roll_out,
  output logic [VAL_WIDTH-1:0] pitch_out,
  output logic                 armed,
  output logic                 failsafe,
  output logic [2:0]           state_out
);

  localparam int LOSS_W = ($clog2(LOSS_TIMEOUT_US + 1) > 16) ? $clog2(LOSS_TIMEOUT_US + 1) : 16;
  localparam int HOLD_W = ($clog2(HOLD_US + 1) > 21) ? $clog2(HOLD_US + 1) : 21;

  localparam logic [LOSS_W-1:0]    LOSS_MAX = LOSS_W'(LOSS_TIMEOUT_US);
  // The transition fires on the cycle whose increment would bring the hold
  // counter to HOLD_US-1, so a gesture seen on exactly HOLD_US consecutive
  // edges (the entry edge included) completes it.
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_US - 2);
  localparam logic [VAL_WIDTH-1:0] CENTER    = VAL_WIDTH'(CENTER_VAL);

  typedef enum logic [2:0] {
    S_DISARMED  = 3'd0,
    S_ARMING    = 3'd1,
    S_ARMED     = 3'd2,
    S_DISARMING = 3'd3,
    S_FAILSAFE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [3:0] pwm_raw, pwm_s1, pwm_s2, pwm_d, pwm_rise;
  logic [LOSS_W-1:0] loss_cnt [4];
  logic sig_ok, thr_low, arm_g, disarm_g, pass_d;

  assign pwm_raw  = {pitch_pwm, roll_pwm, yaw_pwm, throttle_pwm};
  assign pwm_rise = pwm_s2 & ~pwm_d;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      pwm_s1 <= '0;
      pwm_s2 <= '0;
      pwm_d  <= '0;
    end else begin
      pwm_s1 <= pwm_raw;
      pwm_s2 <= pwm_s1;
      pwm_d  <= pwm_s2;
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) loss_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pwm_rise[i])
          loss_cnt[i] <= '0;
        else if (loss_cnt[i] != LOSS_MAX)
          loss_cnt[i] <= loss_cnt[i] + LOSS_W'(1);
      end
    end
  end

  always_comb begin
    sig_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (loss_cnt[i] == LOSS_MAX) sig_ok = 1'b0;
  end

  assign thr_low  = (throttle_val <= VAL_WIDTH'(ARM_THROTTLE_MAX));
  assign arm_g    = thr_low && (yaw_val >= VAL_WIDTH'(ARM_YAW_MIN));
  assign disarm_g = thr_low && (yaw_val <= VAL_WIDTH'(DISARM_YAW_MAX));

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_DISARMED;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Signal loss is tested first in every state so it beats any gesture.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_DISARMED: begin
        if (!sig_ok)     state_d = S_FAILSAFE;
        else if (arm_g)  state_d = S_ARMING;
      end
      S_ARMING: begin
        if (!sig_ok)                 state_d = S_FAILSAFE;
        else if (!arm_g)             state_d = S_DISARMED;
        else if (hold_q == HOLD_LAST) state_d = S_ARMED;
        else                         hold_d  = hold_q + HOLD_W'(1);
      end
      S_ARMED: begin
        if (!sig_ok)        state_d = S_FAILSAFE;
        else if (disarm_g)  state_d = S_DISARMING;
      end
      S_DISARMING: begin
        if (!sig_ok)                 state_d = S_FAILSAFE;
        else if (!disarm_g)          state_d = S_ARMED;
        else if (hold_q == HOLD_LAST) state_d = S_DISARMED;
        else                         hold_d  = hold_q + HOLD_W'(1);
      end
      S_FAILSAFE: begin
        if (sig_ok && thr_low) state_d = S_DISARMED;
      end
      default: state_d = S_DISARMED;
    endcase
    if (state_d != state_q) hold_d = '0;
  end

  // Outputs decode the next state so they change on the same edge as the state.
  assign pass_d = (state_d == S_ARMED) || (state_d == S_DISARMING);

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      throttle_out <= '0;
      yaw_out      <= CENTER;
      roll_out     <= CENTER;
      pitch_out    <= CENTER;
      armed        <= 1'b0;
      failsafe     <= 1'b0;
      state_out    <= 3'd0;
    end else begin
      throttle_out <= pass_d ? throttle_val : '0;
      yaw_out      <= pass_d ? yaw_val      : CENTER;
      roll_out     <= pass_d ? roll_val     : CENTER;
      pitch_out    <= pass_d ? pitch_val    : CENTER;
      armed        <= (state_d == S_ARMED);
      failsafe     <= (state_d == S_FAILSAFE);
      state_out    <= state_d;
    end
  end

endmodule

// File: tb/tb_rc_arming_failsafe.sv
// Bench for rc_arming_failsafe: directed scenarios with randomized sticks,
// PWM phases and gesture segments, compared every cycle against a reference
// model that reasons in terms of "cycles since last pulse" and "cycles the
// gesture has been held".
module tb_rc_arming_failsafe;
  localparam int HOLD = 100;
  localparam int TO   = 500;
  localparam int PER  = 200;
  localparam logic [31:0] SAFE = {8'd0, 8'd125, 8'd125, 8'd125};

  localparam int M_DIS = 0, M_ARMING = 1, M_ARMED = 2, M_DISARMING = 3, M_FS = 4;

  logic us_clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] pwm;
  logic [7:0] thr_v, yaw_v, roll_v, pitch_v;
  logic [7:0] thr_o, yaw_o, roll_o, pitch_o;
  logic armed, failsafe;
  logic [2:0] state_out;

  rc_arming_failsafe #(.HOLD_US(HOLD), .LOSS_TIMEOUT_US(TO)) dut (
    .us_clk(us_clk), .resetn(resetn),
    .throttle_pwm(pwm[0]), .yaw_pwm(pwm[1]), .roll_pwm(pwm[2]), .pitch_pwm(pwm[3]),
    .throttle_val(thr_v), .yaw_val(yaw_v), .roll_val(roll_v), .pitch_val(pitch_v),
    .throttle_out(thr_o), .yaw_out(yaw_o), .roll_out(roll_o), .pitch_out(pitch_o),
    .armed(armed), .failsafe(failsafe), .state_out(state_out)
  );

  always #5 us_clk = ~us_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus state
  logic [3:0] pwm_en;
  int phase [4];
  int cyc;
  bit rnd_axes;
  bit saw_armed;

  // reference model state
  int m_mode, m_run, edge_n;
  int last_clr [4];
  int pend [4];
  logic [3:0] prev_pwm;
  logic [31:0] m_outs;

  function automatic logic [3:0] pwm_level(input int c);
    logic [3:0] l;
    for (int i = 0; i < 4; i++)
      l[i] = pwm_en[i] && (((c + phase[i]) % PER) < 60);
    return l;
  endfunction

  task automatic model_reset();
    m_mode = M_DIS; m_run = 0; edge_n = 0; prev_pwm = '0; m_outs = SAFE;
    for (int i = 0; i < 4; i++) begin last_clr[i] = 0; pend[i] = -1; end
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    bit ok, thr_low, arm, dis;
    edge_n++;
    ok = 1;
    for (int i = 0; i < 4; i++)
      if ((edge_n - 1) - last_clr[i] >= TO) ok = 0;
    for (int i = 0; i < 4; i++)
      if (pend[i] == edge_n) begin last_clr[i] = edge_n; pend[i] = -1; end
    // a pulse first sampled at edge n is seen by the counter two edges later
    for (int i = 0; i < 4; i++)
      if (pwm[i] && !prev_pwm[i]) pend[i] = edge_n + 2;
    prev_pwm = pwm;
    thr_low = (thr_v <= 10);
    arm = thr_low && (yaw_v >= 240);
    dis = thr_low && (yaw_v <= 10);
    case (m_mode)
      M_DIS:
        if (!ok) m_mode = M_FS;
        else if (arm) begin m_mode = M_ARMING; m_run = 1; end
      M_ARMING:
        if (!ok) m_mode = M_FS;
        else if (!arm) m_mode = M_DIS;
        else begin m_run++; if (m_run == HOLD) m_mode = M_ARMED; end
      M_ARMED:
        if (!ok) m_mode = M_FS;
        else if (dis) begin m_mode = M_DISARMING; m_run = 1; end
      M_DISARMING:
        if (!ok) m_mode = M_FS;
        else if (!dis) m_mode = M_ARMED;
        else begin m_run++; if (m_run == HOLD) m_mode = M_DIS; end
      default:
        if (ok && thr_low) m_mode = M_DIS;
    endcase
    m_outs = (m_mode == M_ARMED || m_mode == M_DISARMING) ?
             {thr_v, yaw_v, roll_v, pitch_v} : SAFE;
  endtask

  task automatic cycle();
    @(posedge us_clk);
    model_edge();
    #1;
    check_eq("state", 32'(state_out), 32'(m_mode));
    check_eq("armed", 32'(armed), 32'(m_mode == M_ARMED));
    check_eq("failsafe", 32'(failsafe), 32'(m_mode == M_FS));
    check_eq("outs", {thr_o, yaw_o, roll_o, pitch_o}, m_outs);
    if (armed) saw_armed = 1;
    cyc++;
    pwm = pwm_level(cyc);
    if (rnd_axes) begin
      thr_v   = 8'($urandom_range(11, 255));
      yaw_v   = 8'($urandom);
      roll_v  = 8'($urandom);
      pitch_v = 8'($urandom);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_sticks(input int t, input int y);
    thr_v = 8'(t); yaw_v = 8'(y);
  endtask

  initial begin
    int seg_len, pick;
    cyc = 0; rnd_axes = 0; saw_armed = 0;
    pwm_en = 4'hF;
    for (int i = 0; i < 4; i++) phase[i] = $urandom_range(0, PER - 1);
    thr_v = 0; yaw_v = 125; roll_v = 125; pitch_v = 125;
    pwm = pwm_level(0);
    model_reset();
    repeat (3) @(posedge us_clk);
    check_eq("rst_state", 32'(state_out), 0);
    check_eq("rst_outs", {thr_o, yaw_o, roll_o, pitch_o}, SAFE);
    check_eq("rst_flags", {armed, failsafe}, 0);
    #2 resetn = 1;

    // 1: idle with PWM alive stays disarmed
    run(1000);
    check_eq("t1_state", 32'(state_out), M_DIS);
    check_eq("t1_outs", {thr_o, yaw_o, roll_o, pitch_o}, SAFE);

    // 2: arm with exactly HOLD cycles, then pass-through
    set_sticks(5, 250);
    run(HOLD - 1);
    check_eq("t2_not_yet", 32'(armed), 0);
    run(1);
    check_eq("t2_armed", 32'(armed), 1);
    set_sticks(180, 125); roll_v = 40;
    run(1);
    check_eq("t2_thr", 32'(thr_o), 180);
    check_eq("t2_roll", 32'(roll_o), 40);
    rnd_axes = 1;
    run(200);
    rnd_axes = 0;

    // 5a: full disarm hold
    set_sticks(0, 0); roll_v = 125; pitch_v = 125;
    run(HOLD);
    check_eq("t5_disarmed", 32'(state_out), M_DIS);

    // 3: arm gesture one cycle short
    saw_armed = 0;
    set_sticks(3, 245);
    run(HOLD - 1);
    set_sticks(3, 125);
    run(5);
    check_eq("t3_no_arm", 32'(saw_armed), 0);
    check_eq("t3_state", 32'(state_out), M_DIS);

    // re-arm, then 5b: abandoned disarm and disarm one cycle short
    set_sticks(3, 245);
    run(HOLD);
    check_eq("t5_rearmed", 32'(armed), 1);
    set_sticks(0, 0);
    run(50);
    set_sticks(0, 125);
    run(3);
    check_eq("t5_back_armed", 32'(state_out), M_ARMED);
    set_sticks(0, 0);
    run(HOLD - 1);
    set_sticks(0, 125);
    run(2);
    check_eq("t5_short_disarm", 32'(state_out), M_ARMED);

    // 4: roll channel dies while armed
    set_sticks(180, 125);
    pwm_en[2] = 0;
    run(TO + 20);
    check_eq("t4_failsafe", 32'(failsafe), 1);
    check_eq("t4_thr", 32'(thr_o), 0);
    pwm_en = 4'hF;
    run(600);
    check_eq("t4_stay_fs", 32'(state_out), M_FS);
    set_sticks(0, 125);
    run(3);
    check_eq("t4_recover", 32'(state_out), M_DIS);

    // random gesture segments, occasionally killing a channel
    for (int k = 0; k < 30; k++) begin
      pick = $urandom_range(0, 9);
      thr_v = (pick < 7) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(11, 255));
      pick = $urandom_range(0, 2);
      yaw_v = (pick == 0) ? 8'($urandom_range(0, 10)) :
              (pick == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(11, 239));
      roll_v = 8'($urandom); pitch_v = 8'($urandom);
      pwm_en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      seg_len = $urandom_range(1, 150);
      if (($urandom_range(0, 3) == 0)) seg_len = HOLD + $urandom_range(0, 1) - 1;
      run(seg_len);
    end
    pwm_en = 4'hF;

    // 6: asynchronous reset mid-ARMED
    set_sticks(2, 250);
    run(TO + 10);
    run(HOLD + 5);
    set_sticks(200, 90);
    run(2);
    check_eq("t6_pre_armed", 32'(armed), 1);
    #2 resetn = 0;
    #1;
    check_eq("t6_async_outs", {thr_o, yaw_o, roll_o, pitch_o}, SAFE);
    check_eq("t6_async_state", 32'(state_out), 0);
    check_eq("t6_async_armed", 32'(armed), 0);
    model_reset();

    // dead receiver after reset: FAILSAFE exactly on edge TO+1
    pwm_en = 4'h0;
    pwm = '0;
    set_sticks(0, 125);
    @(posedge us_clk);
    @(posedge us_clk);
    #2 resetn = 1;
    run(TO);
    check_eq("dead_at_to", 32'(state_out), M_DIS);
    run(1);
    check_eq("dead_at_to1", 32'(failsafe), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
